// File: rtl/div_pkg.sv
// Shared types and width helpers for the restoring divider family.
// Pure declarations: no logic, no latency, no flow control.
package div_pkg;

  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic int calc_nw(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
// Purely combinational, zero latency; no flow control.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   rem_in,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   rem_out,
  output logic          q_bit
);

  // One extra MSB so the whole DW+1-bit partial remainder takes part in the trial.
  logic [DW+1:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {2'b00, divisor});
  assign rem_out = q_bit ? (DW+1)'(shifted - {2'b00, divisor}) : shifted[DW:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned 2*DW / DW restoring divider, one quotient bit per cycle (result after NW edges, 0 for /0).
// valid/ready on both sides; result held in DONE until out_ready, one op in flight, no accept in handoff cycle.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter  int DW = DEF_DW,
  localparam int NW = calc_nw(DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(NW);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] dvsr;
  logic [NW-1:0] sreg;
  logic [DW:0]   rem;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_iter;
  logic [DW:0]   rem_step;
  logic          q_bit;

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == CW'(NW - 1));

  div_step #(.DW(DW)) u_step (
    .rem_in  (rem),
    .bit_in  (sreg[NW-1]),
    .divisor (dvsr),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Quotient bits enter sreg from the bottom as dividend bits leave the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvsr        <= '0;
      sreg        <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvsr <= divisor;
            sreg <= dividend;
            rem  <= '0;
            cnt  <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[DW-1:0];
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          sreg <= {sreg[NW-2:0], q_bit};
          rem  <= rem_step;
          if (last_iter) begin
            quotient    <= {sreg[NW-2:0], q_bit};
            remainder   <= rem_step[DW-1:0];
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Iterative restoring divider for unsigned operands. It computes a 2*DW-bit dividend divided by a DW-bit divisor and produces the quotient and remainder. It is the inverse-direction companion to the team's 8x8 multiplier datapath, used to undo or check product scaling. It retires one quotient bit per cycle and uses valid/ready handshakes on both the input and output sides.

Parameters:
DW, 8, divisor and remainder width; dividend and quotient are NW = 2*DW bits wide.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand pair is valid.
in_ready  output  1  block accepts operands; high only in IDLE.
dividend  input  NW  unsigned dividend.
divisor  input  DW  unsigned divisor.
out_valid  output  1  result is valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
quotient  output  NW  unsigned quotient.
remainder  output  DW  unsigned remainder.
div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Reset, asynchronous with rst_n=0:
  - state=IDLE; quotient, remainder and div_by_zero = 0.
  - Internal registers cleared; out_valid=0; in_ready=1 once rst_n=1.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid & in_ready: latch divisor, load the shift register with dividend, clear the partial remainder (DW+1 bits) and the iteration counter.
  - divisor!=0 -> go to CALC. divisor==0 -> go to DONE with quotient = all ones, remainder = dividend[DW-1:0], div_by_zero=1.
- CALC: runs for exactly NW cycles, counter 0..NW-1. Each edge:
  - shifted = {rem[DW-1:0], sreg[NW-1]}; trial = shifted - {0,divisor}.
  - No borrow: rem=trial and the new quotient bit is 1. Borrow: rem=shifted and the new quotient bit is 0.
  - The quotient bit shifts into sreg[0].
  - After iteration NW-1: go to DONE, quotient=sreg, remainder=rem[DW-1:0], div_by_zero=0.
- Latency:
  - Acceptance edge is edge 0; out_valid goes high after edge NW (16 cycles for DW=8).
  - Divide-by-zero: out_valid goes high after edge 0.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are held stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE. out_valid falls and in_ready rises the next cycle.
  - No back-to-back acceptance in the handoff cycle; minimum throughput is one op per NW+2 cycles.
- Result outputs keep their last values in IDLE and are only meaningful when out_valid=1.
- in_valid while busy is ignored: not latched, no error.
- Invariant: dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.
- Width rules:
  - The partial remainder is DW+1 bits because shifted can reach 2*divisor-1.
  - The counter is clog2(NW) bits and must not wrap mid-op.
- Reset asserted mid-CALC or mid-DONE: the operation is aborted, the result is lost, and all outputs return to reset values immediately.

Decomposition:
- Shared package (div_pkg): state enum {IDLE, CALC, DONE}, default DW, and the NW = 2*DW derivation function.
- One combinational sub-module, div_step: inputs rem, next dividend bit, divisor; outputs new rem and quotient bit. It is reused for unrolled variants later.

Test Plan:
- 1000/7 (0x03E8/0x07) -> out_valid exactly 16 cycles after acceptance; quotient=142, remainder=6, div_by_zero=0.
- 65535/255 -> quotient=257, remainder=0. Also 5/9 -> quotient=0, remainder=5.
- 1234/0 (0x04D2/0x00) -> out_valid one cycle after acceptance; quotient=0xFFFF, remainder=0xD2, div_by_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, and in_valid pulses meanwhile are ignored. Release out_ready -> IDLE next cycle, next op gives the correct result.
- Reset pulse during CALC iteration 7 -> out_valid=0, quotient=0, remainder=0 immediately; after release in_ready=1, and a fresh 300/17 returns 17 r 11.
- Random sweep of 10k ops with random out_ready -> every result satisfies the invariant; zero divisors flag correctly.
